// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU widths, the NOP encoding and the next-PC select encoding.
package cpu_pkg;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  typedef enum logic [1:0] {SEL_SEQ, SEL_HOLD, SEL_BRANCH, SEL_JUMP} pc_sel_e;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: fetch-stage bus (decode-stage control, memory port, IF/ID outputs).
// master = fetch unit (drives instruction_addr, ifid_*, pc_wrap); slave = pipeline/memory side.
interface instruction_fetch_if import cpu_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              stall;
  logic              flush;
  logic              branch_taken;
  logic [15:0]       branch_offset;
  logic              jump;
  logic [25:0]       jump_target;
  logic [ADDR_W-1:0] instruction_addr;
  logic [DATA_W-1:0] instruction;
  logic [DATA_W-1:0] ifid_instruction;
  logic [ADDR_W-1:0] ifid_pc_plus1;
  logic              ifid_valid;
  logic              pc_wrap;
  modport master (
    input  stall, flush, branch_taken, branch_offset, jump, jump_target, instruction,
    output instruction_addr, ifid_instruction, ifid_pc_plus1, ifid_valid, pc_wrap
  );
  modport slave (
    output stall, flush, branch_taken, branch_offset, jump, jump_target, instruction,
    input  instruction_addr, ifid_instruction, ifid_pc_plus1, ifid_valid, pc_wrap
  );
endinterface

// File: rtl/pc_reg.sv
// pc_reg: program counter with prioritised next-PC mux and sequential-wrap pulse.
// In: clk, rst (async active-low), jump_i/branch_i (already qualified), stall_i, targets.
// Out: pc_o (registered PC), pc_wrap_o (registered pulse after a sequential max->0 step).
module pc_reg import cpu_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              jump_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic [ADDR_W-1:0] branch_base_i,
  input  logic [ADDR_W-1:0] branch_offset_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_wrap_o
);
  pc_sel_e           sel;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              wrap_q, wrap_d;
  always_comb begin
    sel = jump_i ? SEL_JUMP : branch_i ? SEL_BRANCH : stall_i ? SEL_HOLD : SEL_SEQ;
    pc_d = sel == SEL_JUMP   ? jump_target_i :
           sel == SEL_BRANCH ? branch_base_i + branch_offset_i :
           sel == SEL_HOLD   ? pc_q : pc_q + 1'b1;
    // only a sequential step off the top counts as a wrap; redirects to 0 do not
    wrap_d = sel == SEL_SEQ && &pc_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc_q   <= ADDR_W'(RESET_PC);
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      wrap_q <= wrap_d;
    end
  assign pc_o      = pc_q;
  assign pc_wrap_o = wrap_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC + IF/ID pipeline register for a single-issue fetch stage.
// In: clk, rst (async active-low), bus (master modport: decode control, memory read data).
// Out (via bus): instruction_addr (PC), ifid_instruction/ifid_pc_plus1/ifid_valid, pc_wrap.
module instruction_fetch import cpu_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int unsigned RESET_PC = 0
) (
  input logic clk,
  input logic rst,
  instruction_fetch_if.master bus
);
  logic [ADDR_W-1:0] pc, pc_plus1;
  logic [DATA_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0] ifid_pc1_q, ifid_pc1_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic              jump_en, branch_en, redirect;
  logic              unused_hi;
  // decode-stage redirects only count when decode holds a real instruction
  assign jump_en   = bus.jump & ifid_valid_q;
  assign branch_en = bus.branch_taken & ifid_valid_q;
  assign redirect  = jump_en | branch_en;
  assign pc_plus1  = pc + 1'b1;
  assign unused_hi = ^{bus.jump_target[25:ADDR_W], bus.branch_offset[15:ADDR_W]};
  pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk,
    .rst,
    .stall_i        (bus.stall),
    .jump_i         (jump_en),
    .branch_i       (branch_en),
    .jump_target_i  (bus.jump_target[ADDR_W-1:0]),
    .branch_base_i  (ifid_pc1_q),
    .branch_offset_i(bus.branch_offset[ADDR_W-1:0]),
    .pc_o           (pc),
    .pc_wrap_o      (bus.pc_wrap)
  );
  // redirect beats flush beats stall; a redirect overrides stall entirely
  always_comb begin
    ifid_instr_d = redirect | bus.flush ? DATA_W'(NOP_INSTR) : bus.stall ? ifid_instr_q : bus.instruction;
    ifid_pc1_d   = redirect ? '0 : bus.stall ? ifid_pc1_q : pc_plus1;
    ifid_valid_d = redirect | bus.flush ? 1'b0 : bus.stall ? ifid_valid_q : 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ifid_instr_q <= '0;
      ifid_pc1_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc1_q   <= ifid_pc1_d;
      ifid_valid_q <= ifid_valid_d;
    end
  assign bus.instruction_addr = pc;
  assign bus.ifid_instruction = ifid_instr_q;
  assign bus.ifid_pc_plus1    = ifid_pc1_q;
  assign bus.ifid_valid       = ifid_valid_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for instruction_fetch with directed and random stimulus.
module tb_instruction_fetch;
  import cpu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  instruction_fetch_if #(.ADDR_W(4), .DATA_W(32)) bus();
  instruction_fetch #(.ADDR_W(4), .DATA_W(32), .RESET_PC(0)) dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [31:0] mem(input logic [3:0] a);
    return {16'hC0DE, 4'h0, ~a, 4'h0, a};
  endfunction
  assign bus.instruction = mem(bus.instruction_addr);
  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] ins;
    logic [3:0]  pc1;
    logic        v;
    logic        wrap;
  } exp_t;
  exp_t sb[$];
  logic [3:0]  m_pc, m_pc1;
  logic [31:0] m_ins;
  logic        m_v;
  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive(input logic st, input logic fl, input logic bt, input logic [15:0] off,
                       input logic jp, input logic [25:0] jt);
    bus.stall = st;
    bus.flush = fl;
    bus.branch_taken = bt;
    bus.branch_offset = off;
    bus.jump = jp;
    bus.jump_target = jt;
  endtask
  // model the expected post-edge state, push it, clock, pop and compare
  task automatic step(input logic st, input logic fl, input logic bt, input logic [15:0] off,
                      input logic jp, input logic [25:0] jt);
    exp_t e, g;
    logic redir;
    drive(st, fl, bt, off, jp, jt);
    redir  = m_v && (jp || bt);
    e.addr = (m_v && jp) ? jt[3:0] : (m_v && bt) ? m_pc1 + off[3:0] : st ? m_pc : m_pc + 4'd1;
    e.wrap = !redir && !st && m_pc == 4'hF;
    if (redir) begin
      e.ins = 32'h0; e.pc1 = 4'h0; e.v = 1'b0;
    end else if (fl) begin
      e.ins = 32'h0; e.v = 1'b0; e.pc1 = st ? m_pc1 : m_pc + 4'd1;
    end else if (st) begin
      e.ins = m_ins; e.pc1 = m_pc1; e.v = m_v;
    end else begin
      e.ins = mem(m_pc); e.pc1 = m_pc + 4'd1; e.v = 1'b1;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check("addr", 32'(bus.instruction_addr), 32'(g.addr));
    check("ifid_instr", bus.ifid_instruction, g.ins);
    check("ifid_pc1", 32'(bus.ifid_pc_plus1), 32'(g.pc1));
    check("ifid_valid", 32'(bus.ifid_valid), 32'(g.v));
    check("pc_wrap", 32'(bus.pc_wrap), 32'(g.wrap));
    m_pc = g.addr; m_ins = g.ins; m_pc1 = g.pc1; m_v = g.v;
  endtask
  task automatic nstep();
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
  endtask
  // assert reset away from an edge, check the async clear, release after one edge
  task automatic do_reset();
    rst = 1'b0;
    #2;
    check("rst_addr", 32'(bus.instruction_addr), 32'h0);
    check("rst_valid", 32'(bus.ifid_valid), 32'h0);
    check("rst_instr", bus.ifid_instruction, 32'h0);
    check("rst_pc1", 32'(bus.ifid_pc_plus1), 32'h0);
    check("rst_wrap", 32'(bus.pc_wrap), 32'h0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    rst = 1'b1;
    m_pc = 4'h0; m_pc1 = 4'h0; m_ins = 32'h0; m_v = 1'b0;
    sb.delete();
  endtask
  initial begin
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    #1;
    do_reset();
    // branch ignored while IF/ID is empty
    step(1'b0, 1'b0, 1'b1, 16'h0007, 1'b0, 26'h0);
    check("ign_branch_addr", 32'(bus.instruction_addr), 32'h1);
    // sequential wrap from 0
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      nstep();
      if (k == 15) check("wrap_addr15", 32'(bus.instruction_addr), 32'hF);
      if (k == 16) begin
        check("wrap_addr0", 32'(bus.instruction_addr), 32'h0);
        check("wrap_pulse", 32'(bus.pc_wrap), 32'h1);
        check("wrap_pc1", 32'(bus.ifid_pc_plus1), 32'h0);
      end
      if (k == 17) check("wrap_once", 32'(bus.pc_wrap), 32'h0);
    end
    // backward branch from ifid_pc_plus1=3
    do_reset();
    repeat (3) nstep();
    check("br_base", 32'(bus.ifid_pc_plus1), 32'h3);
    step(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0);
    check("br_addr", 32'(bus.instruction_addr), 32'h1);
    check("br_nop", 32'(bus.ifid_valid), 32'h0);
    // jump beats branch and stall
    nstep();
    step(1'b1, 1'b0, 1'b1, 16'h0003, 1'b1, 26'h3FFFFE9);
    check("jmp_addr", 32'(bus.instruction_addr), 32'h9);
    check("jmp_nop", bus.ifid_instruction, 32'h0);
    // stall freezes, flush under stall clears valid
    nstep();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
      check("stall_addr", 32'(bus.instruction_addr), 32'hA);
      check("stall_instr", bus.ifid_instruction, mem(4'h9));
    end
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
    check("flush_addr", 32'(bus.instruction_addr), 32'hA);
    check("flush_valid", 32'(bus.ifid_valid), 32'h0);
    // mid-run reset with a stall and redirect pending
    nstep();
    nstep();
    drive(1'b1, 1'b0, 1'b1, 16'h0005, 1'b1, 26'h7);
    do_reset();
    nstep();
    check("post_rst_instr", bus.ifid_instruction, mem(4'h0));
    // random mix
    for (int k = 0; k < 300; k++)
      step($urandom_range(3) == 0, $urandom_range(7) == 0, $urandom_range(5) == 0,
           16'($urandom), $urandom_range(7) == 0, 26'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
